// File: rtl/dfr_pkg.sv
// Shared types, mode encodings and arithmetic helpers for the delay-feedback reservoir.
package dfr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        SHIFT = 2'd2
    } state_t;

    localparam logic MODE_EXT    = 1'b0;
    localparam logic MODE_BYPASS = 1'b1;

    // Unsigned add clamped to the largest value representable in 'width' bits.
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned width);
        logic [63:0] maxv;
        logic [63:0] sum;
        maxv = (64'd1 << width) - 64'd1;
        sum  = a + b;
        return (sum > maxv) ? maxv : sum;
    endfunction

endpackage

// File: rtl/reservoir_delay_line.sv
// Shift-register of virtual-node states; node 0 is the head, node DEPTH-1 the tail.
module reservoir_delay_line #(
    parameter int unsigned DEPTH = 10,
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             shift_en,
    input  logic             clear,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic [WIDTH-1:0] tail
);

    logic [WIDTH-1:0] node_q [DEPTH];

    // Clear wins over shift; a shift loads the head and moves every node one place older.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned k = 0; k < DEPTH; k++) node_q[k] <= '0;
        end else if (clear) begin
            for (int unsigned k = 0; k < DEPTH; k++) node_q[k] <= '0;
        end else if (shift_en) begin
            node_q[0] <= din;
            for (int unsigned k = 1; k < DEPTH; k++) node_q[k] <= node_q[k-1];
        end
    end

    assign head = node_q[0];
    assign tail = node_q[DEPTH-1];

endmodule

// File: rtl/dfr_reservoir_engine.sv
// Time-multiplexed delay-feedback reservoir: input + attenuated tail -> nonlinearity -> delay line.
module dfr_reservoir_engine
    import dfr_pkg::*;
#(
    parameter int unsigned VIRTUAL_NODES  = 10,
    parameter int unsigned IN_WIDTH       = 16,
    parameter int unsigned NODE_WIDTH     = 12,
    parameter int unsigned NL_IN_WIDTH    = 16,
    parameter int unsigned NL_OUT_WIDTH   = 16,
    parameter int unsigned FB_ALIGN       = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    localparam int unsigned IDX_W = (VIRTUAL_NODES > 1) ? $clog2(VIRTUAL_NODES) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    din_valid,
    output logic                    din_ready,
    input  logic [IN_WIDTH-1:0]     din,
    input  logic                    cfg_mode,
    input  logic [3:0]              cfg_fb_shift,
    input  logic                    flush,
    output logic                    nl_req,
    output logic [NL_IN_WIDTH-1:0]  nl_data,
    input  logic                    nl_ack,
    input  logic [NL_OUT_WIDTH-1:0] nl_result,
    output logic [NODE_WIDTH-1:0]   dout,
    output logic                    dout_valid,
    output logic [IDX_W-1:0]        node_idx,
    output logic                    frame_done,
    output logic                    timeout_err
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned SUM_W = NL_IN_WIDTH + FB_ALIGN;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VIRTUAL_NODES - 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t                  state_q;
    logic [NL_IN_WIDTH-1:0]  nl_data_q;
    logic                    nl_req_q;
    logic                    mode_q;
    logic [NODE_WIDTH-1:0]   res_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        node_idx_q;
    logic                    dout_valid_q;
    logic                    frame_done_q;
    logic                    timeout_q;

    logic [NODE_WIDTH-1:0]   head;
    logic [NODE_WIDTH-1:0]   tail;
    logic [NODE_WIDTH-1:0]   new_node;
    logic [SUM_W-1:0]        fb;
    logic [NL_IN_WIDTH-1:0]  nl_data_d;
    logic                    transfer;
    logic                    shift_en;
    logic                    unused_bits;

    // Feedback term, saturated pre-nonlinearity sum and the value committed to the head.
    always_comb begin
        fb        = (SUM_W'(tail) << FB_ALIGN) >> cfg_fb_shift;
        nl_data_d = NL_IN_WIDTH'(sat_add(64'(din), 64'(fb), NL_IN_WIDTH));
        new_node  = (mode_q == MODE_BYPASS) ? nl_data_q[NL_IN_WIDTH-1 -: NODE_WIDTH] : res_q;
    end

    assign din_ready = rst_n && (state_q == IDLE) && !flush;
    assign transfer  = din_valid && din_ready;
    assign shift_en  = (state_q == SHIFT) && !flush;

    // Sequencing of accept / nonlinearity handshake / commit, with flush taking priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            nl_data_q    <= '0;
            nl_req_q     <= 1'b0;
            mode_q       <= MODE_EXT;
            res_q        <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            node_idx_q   <= '0;
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
            if (flush) begin
                state_q    <= IDLE;
                nl_req_q   <= 1'b0;
                idx_q      <= '0;
                node_idx_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (transfer) begin
                            nl_data_q <= nl_data_d;
                            mode_q    <= cfg_mode;
                            cnt_q     <= '0;
                            if (cfg_mode == MODE_BYPASS) begin
                                state_q <= SHIFT;
                            end else begin
                                state_q  <= REQ;
                                nl_req_q <= 1'b1;
                            end
                        end
                    end
                    REQ: begin
                        if (nl_ack) begin
                            res_q    <= nl_result[NL_OUT_WIDTH-1 -: NODE_WIDTH];
                            nl_req_q <= 1'b0;
                            state_q  <= SHIFT;
                        end else if (cnt_q == CNT_TERM) begin
                            timeout_q <= 1'b1;
                            nl_req_q  <= 1'b0;
                            state_q   <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    SHIFT: begin
                        dout_valid_q <= 1'b1;
                        frame_done_q <= (idx_q == IDX_LAST);
                        node_idx_q   <= idx_q;
                        idx_q        <= (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        state_q      <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    reservoir_delay_line #(
        .DEPTH (VIRTUAL_NODES),
        .WIDTH (NODE_WIDTH)
    ) u_delay_line (
        .clk      (clk),
        .rst_n    (rst_n),
        .shift_en (shift_en),
        .clear    (flush),
        .din      (new_node),
        .head     (head),
        .tail     (tail)
    );

    // Only the upper NODE_WIDTH bits of the nonlinearity values feed the node state.
    assign unused_bits = ^{nl_result, nl_data_q};

    assign nl_req      = nl_req_q;
    assign nl_data     = nl_data_q;
    assign dout        = head;
    assign dout_valid  = dout_valid_q;
    assign node_idx    = node_idx_q;
    assign frame_done  = frame_done_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_dfr_reservoir_engine.sv
// Self-checking bench for dfr_reservoir_engine with a behavioural reservoir model.
module tb_dfr_reservoir_engine;

    localparam int NV = 10;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        din_valid;
    logic        din_ready;
    logic [15:0] din;
    logic        cfg_mode;
    logic [3:0]  cfg_fb_shift;
    logic        flush;
    logic        nl_req;
    logic [15:0] nl_data;
    logic        nl_ack;
    logic [15:0] nl_result;
    logic [11:0] dout;
    logic        dout_valid;
    logic [3:0]  node_idx;
    logic        frame_done;
    logic        timeout_err;

    dfr_reservoir_engine #(
        .VIRTUAL_NODES  (NV),
        .IN_WIDTH       (16),
        .NODE_WIDTH     (12),
        .NL_IN_WIDTH    (16),
        .NL_OUT_WIDTH   (16),
        .FB_ALIGN       (3),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_valid    (din_valid),
        .din_ready    (din_ready),
        .din          (din),
        .cfg_mode     (cfg_mode),
        .cfg_fb_shift (cfg_fb_shift),
        .flush        (flush),
        .nl_req       (nl_req),
        .nl_data      (nl_data),
        .nl_ack       (nl_ack),
        .nl_result    (nl_result),
        .dout         (dout),
        .dout_valid   (dout_valid),
        .node_idx     (node_idx),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: reservoir contents (index 0 = newest) and next commit index.
    logic [11:0] m_nodes [NV];
    int          m_idx;

    // Per-cycle expectations consumed by the compare process.
    bit          chk_en;
    bit          exp_rdy, exp_req, exp_dv, exp_to, exp_fd, chk_nl;
    int          exp_idx;
    logic [15:0] exp_nl;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("din_ready",   32'(din_ready),   32'(exp_rdy));
            check("nl_req",      32'(nl_req),      32'(exp_req));
            check("dout_valid",  32'(dout_valid),  32'(exp_dv));
            check("timeout_err", 32'(timeout_err), 32'(exp_to));
            check("frame_done",  32'(frame_done),  32'(exp_fd));
            check("dout",        32'(dout),        32'(m_nodes[0]));
            if (exp_dv) check("node_idx", 32'(node_idx), 32'(exp_idx));
            if (chk_nl) check("nl_data",  32'(nl_data),  32'(exp_nl));
        end
    end

    function automatic logic [15:0] model_nl(input logic [15:0] d, input int sh);
        longint fbv, s;
        fbv = (longint'(m_nodes[NV-1]) * 8) >> sh;
        s   = longint'(d) + fbv;
        if (s > 65535) s = 65535;
        return 16'(s);
    endfunction

    task automatic model_commit(input logic [11:0] v);
        for (int k = NV - 1; k > 0; k--) m_nodes[k] = m_nodes[k-1];
        m_nodes[0] = v;
        exp_idx = m_idx;
        exp_fd  = (m_idx == NV - 1);
        m_idx   = (m_idx + 1) % NV;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NV; k++) m_nodes[k] = '0;
        m_idx   = 0;
        exp_idx = 0;
    endtask

    task automatic idle_exp();
        exp_rdy = 1; exp_req = 0; exp_dv = 0; exp_to = 0; exp_fd = 0; chk_nl = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_inputs();
        din_valid    = 0;
        din          = 16'($urandom);
        cfg_mode     = 1'($urandom);
        cfg_fb_shift = 4'($urandom);
        nl_result    = 16'($urandom);
    endtask

    // Present one sample for a single cycle; it is accepted on the closing edge.
    task automatic present(input logic [15:0] d, input int sh, input logic mode, output logic [15:0] nl);
        next_cycle();
        idle_exp();
        din_valid = 1; din = d; cfg_fb_shift = 4'(sh); cfg_mode = mode;
        nl = model_nl(d, sh);
    endtask

    task automatic send_bypass(input logic [15:0] d, input int sh);
        logic [15:0] nl;
        present(d, sh, 1'b1, nl);
        next_cycle();
        junk_inputs();
        exp_rdy = 0; exp_nl = nl; chk_nl = 1;
        next_cycle();
        model_commit(nl[15:4]);
        exp_rdy = 1; exp_dv = 1;
        @(negedge clk); #1;
    endtask

    task automatic send_ext(input logic [15:0] d, input int sh, input int dly, input logic [15:0] res);
        logic [15:0] nl;
        present(d, sh, 1'b0, nl);
        for (int i = 0; i <= dly; i++) begin
            next_cycle();
            junk_inputs();
            exp_rdy = 0; exp_req = 1; exp_nl = nl; chk_nl = 1;
            nl_ack = (i == dly);
            if (i == dly) nl_result = res;
        end
        next_cycle();
        junk_inputs(); nl_ack = 0;
        exp_req = 0;
        next_cycle();
        model_commit(res[15:4]);
        exp_rdy = 1; exp_dv = 1;
        @(negedge clk); #1;
    endtask

    task automatic send_timeout(input logic [15:0] d, input int sh);
        logic [15:0] nl;
        present(d, sh, 1'b0, nl);
        for (int i = 0; i < TO; i++) begin
            next_cycle();
            junk_inputs();
            exp_rdy = 0; exp_req = 1; exp_nl = nl; chk_nl = 1;
        end
        next_cycle();
        exp_req = 0; exp_rdy = 1; exp_to = 1;
        @(negedge clk); #1;
    endtask

    task automatic flush_idle();
        next_cycle();
        idle_exp();
        flush = 1; din_valid = 1; din = 16'($urandom); cfg_mode = 1'($urandom);
        exp_rdy = 0;
        next_cycle();
        flush = 0; din_valid = 0;
        idle_exp();
        model_clear();
        @(negedge clk); #1;
        check("flush_idx", 32'(node_idx), 32'd0);
    endtask

    task automatic flush_req();
        logic [15:0] nl;
        present(16'($urandom), $urandom_range(0, 15), 1'b0, nl);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            junk_inputs();
            exp_rdy = 0; exp_req = 1; exp_nl = nl; chk_nl = 1;
            if (i == 2) begin flush = 1; nl_ack = 1; end
        end
        next_cycle();
        flush = 0; nl_ack = 1;
        idle_exp();
        model_clear();
        next_cycle();
        nl_ack = 0;
        idle_exp();
        @(negedge clk); #1;
        check("flushreq_req",  32'(nl_req), 32'd0);
        check("flushreq_dout", 32'(dout),   32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] nl;
        rst_n = 0; chk_en = 0;
        din_valid = 0; din = '0; cfg_mode = 0; cfg_fb_shift = '0; flush = 0;
        nl_ack = 0; nl_result = '0;
        model_clear();
        idle_exp();
        #2;
        check("rst_ready", 32'(din_ready),  32'd0);
        check("rst_req",   32'(nl_req),     32'd0);
        check("rst_nl",    32'(nl_data),    32'd0);
        check("rst_dout",  32'(dout),       32'd0);
        check("rst_dv",    32'(dout_valid), 32'd0);
        check("rst_idx",   32'(node_idx),   32'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1; chk_en = 1;
        #1;
        check("ready_after_rst", 32'(din_ready), 32'd1);

        // Bypass basics, feedback, attenuation and saturation.
        send_bypass(16'h1230, 0);
        check("t1_dout", 32'(dout), 32'h123);
        check("t1_idx",  32'(node_idx), 32'd0);
        send_bypass(16'h1230, 0);
        send_bypass(16'h1230, 5);
        for (int i = 3; i < NV; i++) send_bypass(16'($urandom), $urandom_range(0, 15));
        check("frame_done_10th", 32'(frame_done), 32'd1);
        check("idx_10th",        32'(node_idx),   32'd9);
        send_bypass(16'h0010, 0);
        check("t2_nl",   32'(nl_data),    32'h0928);
        check("t2_dout", 32'(dout),       32'h092);
        check("t2_wrap", 32'(node_idx),   32'd0);
        check("t2_fd",   32'(frame_done), 32'd0);
        send_bypass(16'h0010, 2);
        check("t2b_nl",   32'(nl_data), 32'h0256);
        check("t2b_dout", 32'(dout),    32'h025);
        send_bypass(16'hFFF0, 0);
        check("t3_nl",   32'(nl_data), 32'hFFFF);
        check("t3_dout", 32'(dout),    32'hFFF);

        // External nonlinearity, stray ack in IDLE.
        flush_idle();
        next_cycle(); idle_exp(); nl_ack = 1; nl_result = 16'h5555;
        next_cycle(); idle_exp(); nl_ack = 0;
        send_ext(16'h1000, 0, 5, 16'hABCD);
        check("t4_nl",   32'(nl_data), 32'h1000);
        check("t4_dout", 32'(dout),    32'hABC);

        // Timeout leaves the reservoir untouched.
        send_timeout(16'($urandom), 0);
        check("t5_idx",  32'(node_idx), 32'd0);
        check("t5_dout", 32'(dout),     32'hABC);
        next_cycle(); idle_exp();

        flush_req();

        // Randomised mix of operations.
        for (int n = 0; n < 80; n++) begin
            int r;
            r = $urandom_range(0, 9);
            if (r <= 4)      send_bypass(16'($urandom), $urandom_range(0, 15));
            else if (r <= 7) send_ext(16'($urandom), $urandom_range(0, 15), $urandom_range(0, TO - 1), 16'($urandom));
            else if (r == 8) send_timeout(16'($urandom), $urandom_range(0, 15));
            else             flush_idle();
        end

        // Asynchronous reset in the middle of a request.
        send_bypass(16'hF00F, 0);
        present(16'h4321, 0, 1'b0, nl);
        next_cycle(); junk_inputs(); exp_rdy = 0; exp_req = 1; exp_nl = nl; chk_nl = 1;
        next_cycle(); junk_inputs();
        chk_en = 0; rst_n = 0;
        #1;
        check("arst_req",   32'(nl_req),      32'd0);
        check("arst_nl",    32'(nl_data),     32'd0);
        check("arst_dout",  32'(dout),        32'd0);
        check("arst_dv",    32'(dout_valid),  32'd0);
        check("arst_idx",   32'(node_idx),    32'd0);
        check("arst_fd",    32'(frame_done),  32'd0);
        check("arst_to",    32'(timeout_err), 32'd0);
        check("arst_ready", 32'(din_ready),   32'd0);
        next_cycle();
        rst_n = 1; model_clear(); idle_exp(); chk_en = 1;
        for (int n = 0; n < 4; n++) send_bypass(16'($urandom), $urandom_range(0, 15));
        next_cycle(); idle_exp();
        @(negedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dfr_reservoir_engine.md
Name: dfr_reservoir_engine

Overview:
Parametrised time-multiplexed delay-feedback reservoir. Each input sample is summed with the scaled oldest virtual-node state and passed through a nonlinearity, either an external analogue/ASIC function over a request/acknowledge interface or an internal linear bypass. The result is pushed into a VIRTUAL_NODES-deep delay line. It sits between the input-mask stream source and the readout/training logic. It adds configurable depth and width, programmable feedback attenuation, saturation, a timeout, frame tracking and flush.

Parameters:
VIRTUAL_NODES, 10, delay-line depth (>=2)
IN_WIDTH, 16, input sample width (<= NL_IN_WIDTH)
NODE_WIDTH, 12, stored node state width (<= NL_IN_WIDTH, <= NL_OUT_WIDTH)
NL_IN_WIDTH, 16, width of value sent to nonlinearity
NL_OUT_WIDTH, 16, width of nonlinearity result
FB_ALIGN, 3, fixed left shift applied to the tail node before summing
TIMEOUT_CYCLES, 4096, maximum cycles waiting for nl_ack

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
din_valid  in  1  input sample valid
din_ready  out  1  engine can accept a sample
din  in  IN_WIDTH  masked input sample
cfg_mode  in  1  0 = external nonlinearity, 1 = internal bypass
cfg_fb_shift  in  4  feedback right-shift (attenuation)
flush  in  1  clear delay line and index
nl_req  out  1  request to nonlinearity; level, held until ack
nl_data  out  NL_IN_WIDTH  value to nonlinearity; stable while nl_req is high
nl_ack  in  1  nonlinearity result valid
nl_result  in  NL_OUT_WIDTH  nonlinearity result
dout  out  NODE_WIDTH  newest node state (head)
dout_valid  out  1  one-cycle pulse when a new node is committed
node_idx  out  $clog2(VIRTUAL_NODES)  index of the node in dout
frame_done  out  1  pulse coincident with dout_valid when node_idx == VIRTUAL_NODES-1
timeout_err  out  1  one-cycle pulse on nonlinearity timeout

Behaviour:
- Reset (rst_n low, async): state IDLE; all nodes 0; node_idx 0; nl_req 0; nl_data 0; dout_valid, frame_done and timeout_err 0. din_ready goes high after reset releases.
- FSM states: IDLE, REQ, SHIFT.
- IDLE: din_ready = !flush. A transfer occurs when din_valid && din_ready.
- On transfer, register nl_data = sat(din + ((tail << FB_ALIGN) >> cfg_fb_shift)).
  - tail is the oldest node, zero-extended to NL_IN_WIDTH+FB_ALIGN bits before the shift.
  - The sum is unsigned and saturates to 2^NL_IN_WIDTH-1.
- Transitions from IDLE on transfer: cfg_mode=0 -> REQ; cfg_mode=1 -> SHIFT. cfg_mode and cfg_fb_shift are sampled only at transfer.
- REQ:
  - nl_req=1 and din_ready=0.
  - A timeout counter clears on entry to REQ.
  - nl_ack high -> capture new = nl_result[NL_OUT_WIDTH-1 -: NODE_WIDTH], go to SHIFT.
  - Counter reaching TIMEOUT_CYCLES-1 without ack -> timeout_err pulse, nodes unchanged, sample dropped, go to IDLE.
  - Ack and terminal count in the same cycle: ack wins.
  - nl_ack outside REQ is ignored.
- Bypass mode: new = nl_data[NL_IN_WIDTH-1 -: NODE_WIDTH].
- SHIFT (1 cycle): at the end of the cycle the head takes new and node[k+1] takes node[k]. dout_valid, dout, node_idx and frame_done are registered and visible in the following cycle, which is also the cycle the FSM returns to IDLE.
- Latency:
  - Bypass: transfer edge t -> dout_valid high in cycle t+2. Maximum throughput is one sample per 2 cycles.
  - External: ack at cycle t -> dout_valid in cycle t+2.
- node_idx increments after each commit and wraps VIRTUAL_NODES-1 -> 0. A timeout does not advance node_idx.
- flush (any state, highest priority): nodes and node_idx cleared next cycle, nl_req dropped, FSM to IDLE, any in-flight sample discarded without dout_valid. A flush coincident with ack discards the ack.
- nl_req deasserts the cycle after ack is sampled, never combinationally from ack.

Decomposition:
- Package dfr_pkg: FSM state enum (IDLE, REQ, SHIFT), mode constants MODE_EXT=0 and MODE_BYPASS=1, and a saturating-add function.
- Sub-module reservoir_delay_line (params DEPTH, WIDTH; ports clk, rst_n, shift_en, clear, din, head, tail) holds the node registers.
- The FSM, arithmetic and counters stay in the top module.

Test Plan:
1. Bypass, fb_shift=0, nodes zero, din=0x1230 at edge t -> dout=0x123, dout_valid only in cycle t+2, node_idx=0, din_ready low in cycle t+1.
2. Bypass, after 10 samples with the first =0x1230 (tail 0x123), din=0x0010 -> nl_data=0x0928, dout=0x092. Repeat with fb_shift=2 -> nl_data=0x0256, dout=0x025.
3. Saturation: tail 0x123, din=0xFFF0 -> nl_data=0xFFFF, dout=0xFFF.
4. External mode: din=0x1000, tail 0 -> nl_req high with nl_data=0x1000; ack after 5 cycles with nl_result=0xABCD -> nl_req low the next cycle, dout=0xABC, dout_valid 2 cycles after ack. A stray ack while in IDLE is ignored.
5. Timeout, TIMEOUT_CYCLES=8, no ack -> nl_req high for 8 cycles, one timeout_err pulse, dout_valid never asserts, node_idx and nodes unchanged, din_ready returns high.
6. Frame, flush and reset:
   - 10 bypass samples -> frame_done only with the 10th dout_valid, node_idx wraps to 0.
   - flush during REQ -> nl_req drops, all nodes 0, a later ack is ignored.
   - rst_n low mid-REQ -> all outputs 0 immediately.
